// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the access-size and FSM-state encodings, plus the helper functions
// for alignment checking, byte-enable generation, store lane replication
// and load extension.
// No ports; imported by dmem_responder.
package dmem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  // Halfwords need an even address and words a 4-byte-aligned one.
  // The reserved size 11 falls into the word branch.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

  // Little-endian byte enables for a store.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Right-justified store data replicated onto every lane it could occupy.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: lane_wdata = {4{wdata[7:0]}};
      SZ_HALF: lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  // Selects the addressed lane from a RAM word and sign/zero extends it.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                              input logic [1:0] off, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extend = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 2**AW words of 32 bits.
// It has per-byte write enables and a registered read. The read register
// only updates when re is high, so it holds the last value read.
// Ports: clk; re read enable; we[3:0] byte write enables; addr word index;
//        wdata write data; rdata registered read data.
module dmem_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Byte-lane writes; contents are never cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read, held between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
// It accepts one load/store at a time and answers LAT cycles after
// acceptance. While a request is outstanding it stalls the pipeline. It also
// performs lane selection, load extension and alignment checking.
// Ports: clk, rst (sync, active-high); req_valid/req_we/req_size/req_signed/
//        req_addr/req_wdata request; stall hold to pipeline; resp_done
//        response pulse; resp_rdata extended load data; addr_err misaligned.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int AW  = 10,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_done,
  output logic [31:0] resp_rdata,
  output logic        addr_err
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept;
  logic        c_we, c_signed;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata;
  logic        cur_we, cur_err;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic        ram_re;
  logic [3:0]  ram_we;
  logic [31:0] ram_q;
  logic [31:0] rdata_hold;
  logic        unused_addr_bits;

  // In IDLE the live request drives the RAM, because with LAT = 1 the read
  // has to be issued at the very edge that accepts the request. Afterwards
  // the captured copy drives it.
  always_comb begin
    if (state == IDLE) begin
      cur_we   = req_we;
      cur_size = req_size;
      cur_addr = req_addr;
    end else begin
      cur_we   = c_we;
      cur_size = c_size;
      cur_addr = c_addr;
    end
  end

  assign cur_err          = misaligned(cur_size, cur_addr[1:0]);
  assign unused_addr_bits = ^cur_addr[31:AW+2];
  assign stall            = req_valid & ~resp_done;

  // Read on the edge that enters RESP. Write at the end of RESP, so a reset
  // at any earlier point discards the store.
  assign ram_re = (state != RESP) && (state_next == RESP) && !cur_we && !cur_err;
  assign ram_we = (state == RESP && c_we && !cur_err && !rst) ?
                  byte_en(c_size, c_addr[1:0]) : 4'b0000;

  dmem_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (cur_addr[AW+1:2]),
    .wdata (lane_wdata(c_size, c_wdata)),
    .rdata (ram_q)
  );

  // Next-state and counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          cnt_next   = LAT_M1;
          state_next = (LAT == 1) ? RESP : BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
        end else begin
          state_next = BUSY;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response data is live only in RESP. Outside RESP the last response is
  // replayed from rdata_hold.
  always_comb begin
    resp_rdata = rdata_hold;
    if (state == RESP) begin
      if (c_we || cur_err) begin
        resp_rdata = 32'h0000_0000;
      end else begin
        resp_rdata = load_extend(c_size, c_signed, c_addr[1:0], ram_q);
      end
    end else begin
      resp_rdata = rdata_hold;
    end
  end

  // FSM state, counter and the registered response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_done  <= 1'b0;
      addr_err   <= 1'b0;
      rdata_hold <= 32'h0000_0000;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      resp_done <= (state_next == RESP);
      addr_err  <= (state_next == RESP) && cur_err;
      if (state == RESP) begin
        rdata_hold <= resp_rdata;
      end
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      c_we     <= req_we;
      c_size   <= req_size;
      c_signed <= req_signed;
      c_addr   <= req_addr;
      c_wdata  <= req_wdata;
    end
  end

endmodule
